// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic phase controller: green/yellow/all-red rotation with
// a pedestrian walk interval and a flashing-yellow fallback mode.
module traffic_phase_ctrl #(
    parameter int NDIR = 2,
    parameter int TW   = 8,
    parameter int DW   = (NDIR > 1) ? $clog2(NDIR) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            flash_mode,
    input  logic            ped_req,
    input  logic [TW-1:0]   grn_len,
    input  logic [TW-1:0]   yel_len,
    input  logic [TW-1:0]   clr_len,
    output logic [NDIR-1:0] red_out,
    output logic [NDIR-1:0] yel_out,
    output logic [NDIR-1:0] grn_out,
    output logic            ped_walk,
    output logic [DW-1:0]   active_dir,
    output logic            cycle_done
);

    typedef enum logic [2:0] {
        IDLE,
        GREEN,
        YELLOW,
        ALLRED,
        WALK,
        FLASH
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            ped_pending;
    logic            blink;
    logic            expired;
    logic            wrap;
    logic [DW-1:0]   next_dir;
    logic [NDIR-1:0] dir_sel;

    // A zero length still occupies one cycle, so it loads the same as a length of 1.
    function automatic logic [TW-1:0] load_of(input logic [TW-1:0] len);
        return (len == '0) ? '0 : len - TW'(1);
    endfunction

    assign expired  = (timer == '0);
    assign wrap     = (active_dir == DW'(NDIR - 1));
    assign next_dir = wrap ? '0 : active_dir + DW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            active_dir  <= '0;
            timer       <= '0;
            ped_pending <= 1'b0;
            blink       <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (ped_req && state != WALK && state != IDLE)
                ped_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (flash_mode) begin
                        state <= FLASH;
                        timer <= load_of(yel_len);
                        blink <= 1'b1;
                    end else if (en) begin
                        state      <= GREEN;
                        active_dir <= '0;
                        timer      <= load_of(grn_len);
                    end
                end
                GREEN: begin
                    if (expired) begin
                        state <= YELLOW;
                        timer <= load_of(yel_len);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                YELLOW: begin
                    if (expired) begin
                        state <= ALLRED;
                        timer <= load_of(clr_len);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ALLRED: begin
                    if (!expired) begin
                        timer <= timer - TW'(1);
                    end else if (flash_mode) begin
                        state <= FLASH;
                        timer <= load_of(yel_len);
                        blink <= 1'b1;
                    end else if (!en) begin
                        state      <= IDLE;
                        active_dir <= '0;
                    end else if (ped_pending) begin
                        state <= WALK;
                        timer <= load_of(grn_len);
                    end else begin
                        state      <= GREEN;
                        active_dir <= next_dir;
                        cycle_done <= wrap;
                        timer      <= load_of(grn_len);
                    end
                end
                WALK: begin
                    if (expired) begin
                        state       <= GREEN;
                        active_dir  <= next_dir;
                        cycle_done  <= wrap;
                        timer       <= load_of(grn_len);
                        ped_pending <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                FLASH: begin
                    if (!flash_mode) begin
                        state <= ALLRED;
                        timer <= load_of(clr_len);
                    end else if (expired) begin
                        blink <= ~blink;
                        timer <= load_of(yel_len);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NDIR; gi++) begin : g_dir_sel
        assign dir_sel[gi] = (active_dir == DW'(gi));
    end

    // Lamps decode purely from registers, so reset drives them without a clock edge.
    always_comb begin
        red_out  = '1;
        yel_out  = '0;
        grn_out  = '0;
        ped_walk = 1'b0;
        case (state)
            GREEN: begin
                grn_out = dir_sel;
                red_out = ~dir_sel;
            end
            YELLOW: begin
                yel_out = dir_sel;
                red_out = ~dir_sel;
            end
            WALK:  ped_walk = 1'b1;
            FLASH: begin
                red_out = '0;
                yel_out = {NDIR{blink}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with NDIR=2: each task checks one
// scenario against a hand-written per-cycle lamp table.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       flash_mode = 1'b0;
    logic       ped_req = 1'b0;
    logic [7:0] grn_len = 8'd4;
    logic [7:0] yel_len = 8'd2;
    logic [7:0] clr_len = 8'd1;
    logic [1:0] red_out, yel_out, grn_out;
    logic       ped_walk;
    logic [0:0] active_dir;
    logic       cycle_done;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_ctrl #(.NDIR(2), .TW(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .flash_mode (flash_mode),
        .ped_req    (ped_req),
        .grn_len    (grn_len),
        .yel_len    (yel_len),
        .clr_len    (clr_len),
        .red_out    (red_out),
        .yel_out    (yel_out),
        .grn_out    (grn_out),
        .ped_walk   (ped_walk),
        .active_dir (active_dir),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    // {red[1:0], yel[1:0], grn[1:0], ped_walk, active_dir, cycle_done}
    wire [8:0] obs = {red_out, yel_out, grn_out, ped_walk, active_dir, cycle_done};

    localparam logic [8:0] IDL = 9'b11_00_00_0_0_0;
    localparam logic [8:0] G0  = 9'b10_00_01_0_0_0;
    localparam logic [8:0] G0C = 9'b10_00_01_0_0_1;
    localparam logic [8:0] Y0  = 9'b10_01_00_0_0_0;
    localparam logic [8:0] AR0 = 9'b11_00_00_0_0_0;
    localparam logic [8:0] G1  = 9'b01_00_10_0_1_0;
    localparam logic [8:0] Y1  = 9'b01_10_00_0_1_0;
    localparam logic [8:0] AR1 = 9'b11_00_00_0_1_0;
    localparam logic [8:0] W0  = 9'b11_00_00_1_0_0;
    localparam logic [8:0] F1  = 9'b00_11_00_0_0_0;
    localparam logic [8:0] F0  = 9'b00_00_00_0_0_0;

    localparam logic [8:0] T_BASIC [0:18] = '{
        G0, G0, G0, G0, Y0, Y0, AR0, G1, G1, G1, G1, Y1, Y1, AR1, G0C, G0, G0, G0, Y0};
    localparam logic [8:0] T_PED [0:19] = '{
        G0, G0, G0, G0, Y0, Y0, AR0, W0, W0, W0, W0, G1, G1, G1, G1, Y1, Y1, AR1, G0C, G0};
    localparam logic [8:0] T_FLASH [0:17] = '{
        G0, G0, G0, G0, Y0, Y0, AR0, F1, F1, F0, F0, F1, F1, AR0, G1, G1, G1, G1};
    localparam logic [8:0] T_ZERO [0:4] = '{G0, Y0, Y0, AR0, G1};
    localparam logic [8:0] T_RESTART [0:4] = '{G0, G0, G0, G0, Y0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn       = 1'b0;
        en         = 1'b0;
        flash_mode = 1'b0;
        ped_req    = 1'b0;
        grn_len    = 8'd4;
        yel_len    = 8'd2;
        clr_len    = 8'd1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #3;
        n_cmp++;
        if (obs !== IDL) begin
            n_bad++;
            $display("FAIL reset_held: got %b expected %b", obs, IDL);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== IDL) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs, IDL);
            end
            tick();
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_cycle;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            n_cmp++;
            if (obs !== T_BASIC[i]) begin
                n_bad++;
                $display("FAIL basic[%0d]: got %b expected %b", i, obs, T_BASIC[i]);
            end
        end
        $display("test_basic_cycle done");
    endtask

    task automatic test_ped;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ped_req = (i == 1 || i == 9);
            tick();
            n_cmp++;
            if (obs !== T_PED[i]) begin
                n_bad++;
                $display("FAIL ped[%0d]: got %b expected %b", i, obs, T_PED[i]);
            end
        end
        ped_req = 1'b0;
        $display("test_ped done");
    endtask

    task automatic test_flash;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            flash_mode = (i >= 2 && i < 13);
            tick();
            n_cmp++;
            if (obs !== T_FLASH[i]) begin
                n_bad++;
                $display("FAIL flash[%0d]: got %b expected %b", i, obs, T_FLASH[i]);
            end
        end
        flash_mode = 1'b0;
        $display("test_flash done");
    endtask

    task automatic test_grn_len;
        int cnt;
        do_reset();
        grn_len = 8'd0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (obs !== T_ZERO[i]) begin
                n_bad++;
                $display("FAIL grn_zero[%0d]: got %b expected %b", i, obs, T_ZERO[i]);
            end
        end

        do_reset();
        grn_len = 8'd255;
        en = 1'b1;
        tick();
        cnt = 0;
        while (grn_out == 2'b01 && cnt < 300) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 255) begin
            n_bad++;
            $display("FAIL grn_255_len: got %0d cycles expected 255", cnt);
        end
        n_cmp++;
        if (obs !== Y0) begin
            n_bad++;
            $display("FAIL grn_255_next: got %b expected %b", obs, Y0);
        end

        do_reset();
        grn_len = 8'd4;
        en = 1'b1;
        tick();
        grn_len = 8'd10;
        cnt = 0;
        while (grn_out == 2'b01 && cnt < 300) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 4) begin
            n_bad++;
            $display("FAIL grn_midchange_len: got %0d cycles expected 4", cnt);
        end
        grn_len = 8'd4;
        $display("test_grn_len done");
    endtask

    task automatic test_async_reset;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (obs !== Y0) begin
            n_bad++;
            $display("FAIL areset_pre: got %b expected %b", obs, Y0);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== IDL) begin
            n_bad++;
            $display("FAIL areset_immediate: got %b expected %b", obs, IDL);
        end
        tick();
        n_cmp++;
        if (obs !== IDL) begin
            n_bad++;
            $display("FAIL areset_held: got %b expected %b", obs, IDL);
        end
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (obs !== T_RESTART[i]) begin
                n_bad++;
                $display("FAIL areset_restart[%0d]: got %b expected %b", i, obs, T_RESTART[i]);
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_ped();
        test_flash();
        test_grn_len();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
